// File: rtl/croc_pkg.sv
// Shared OBI/regbus types for the croc peripheral path, plus the
// state encoding and default timeout read data for the OBI-to-regbus bridge.
package croc_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    logic        a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic [2:0]  rid;
    logic        err;
    logic        r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    sbr_obi_r_chan_t r;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } bridge_state_e;

  localparam logic [31:0] ErrRdataDefault = 32'hBADC_AB1E;

endpackage

// File: rtl/croc_obi_reg_bridge.sv
// Single-outstanding OBI subordinate to regbus bridge with a hang watchdog
// that turns a stuck regbus access into an OBI error response.
module croc_obi_reg_bridge
  import croc_pkg::*;
#(
  parameter type         obi_req_t     = croc_pkg::sbr_obi_req_t,
  parameter type         obi_rsp_t     = croc_pkg::sbr_obi_rsp_t,
  parameter type         reg_req_t     = croc_pkg::reg_req_t,
  parameter type         reg_rsp_t     = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [31:0] ErrRdata      = ErrRdataDefault
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i,
  output logic     timeout_o
);

  localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLimit = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;
  localparam logic [CntW-1:0] CntSat   = CntW'(TimeoutCycles);

  bridge_state_e   state_q, state_d;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic            we_q, err_q;
  logic [3:0]      be_q;
  logic [2:0]      aid_q;
  logic [CntW-1:0] cnt_q;

  logic gnt, in_access, fire_to;
  logic unused_a_optional;

  assign unused_a_optional = obi_req_i.a.a_optional;

  // Outputs are gated by rst_i so a reset mid-access drops valid immediately.
  assign gnt       = obi_req_i.req && !rst_i && (state_q == IDLE || state_q == RESP);
  assign in_access = (state_q == ACCESS) && !rst_i;
  assign fire_to   = (TimeoutCycles != 0) && in_access && !reg_rsp_i.ready
                     && (cnt_q == CntLimit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt) state_d = ACCESS;
      ACCESS:  if (reg_rsp_i.ready || fire_to) state_d = RESP;
      RESP:    state_d = gnt ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = gnt;
    obi_rsp_o.rvalid       = (state_q == RESP) && !rst_i;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = aid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;

    reg_req_o       = '0;
    reg_req_o.valid = in_access;
    reg_req_o.addr  = addr_q;
    reg_req_o.write = we_q;
    reg_req_o.wdata = wdata_q;
    reg_req_o.wstrb = we_q ? be_q : 4'b0000;

    timeout_o = fire_to;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      aid_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        addr_q  <= obi_req_i.a.addr;
        we_q    <= obi_req_i.a.we;
        be_q    <= obi_req_i.a.be;
        wdata_q <= obi_req_i.a.wdata;
        aid_q   <= obi_req_i.a.aid;
      end
      // Ready wins over a simultaneous watchdog expiry.
      if (in_access && reg_rsp_i.ready) begin
        rdata_q <= we_q ? 32'h0 : reg_rsp_i.rdata;
        err_q   <= reg_rsp_i.error;
      end else if (fire_to) begin
        rdata_q <= ErrRdata;
        err_q   <= 1'b1;
      end
      if (gnt) begin
        cnt_q <= '0;
      end else if (in_access && !reg_rsp_i.ready && cnt_q != CntSat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_croc_obi_reg_bridge.sv
// Directed bench for croc_obi_reg_bridge: table-driven single transactions
// plus hand-written back-to-back and reset-mid-access sequences.
module tb_croc_obi_reg_bridge;
  import croc_pkg::*;

  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  sbr_obi_req_t obi_req;
  sbr_obi_rsp_t obi_rsp;
  reg_req_t     reg_req;
  reg_rsp_t     reg_rsp;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  croc_obi_reg_bridge #(.TimeoutCycles(TO)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_req_i (obi_req),
    .obi_rsp_o (obi_rsp),
    .reg_req_o (reg_req),
    .reg_rsp_i (reg_rsp),
    .timeout_o (timeout)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  aid;
    int          delay;      // ACCESS cycles with ready=0 before ready
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int k;
    logic done;
    @(negedge clk);
    obi_req.req     = 1'b1;
    obi_req.a.addr  = v.addr;
    obi_req.a.we    = v.we;
    obi_req.a.be    = v.be;
    obi_req.a.wdata = v.wdata;
    obi_req.a.aid   = v.aid;
    #1 chk("gnt", 32'(obi_rsp.gnt), 32'd1);
    chk("valid_before", 32'(reg_req.valid), 32'd0);
    @(negedge clk);
    obi_req.req     = 1'b0;
    obi_req.a.wdata = ~v.wdata;
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      reg_rsp.ready = (k == v.delay);
      reg_rsp.rdata = v.rsp_rdata;
      reg_rsp.error = v.rsp_err;
      #1;
      chk("valid", 32'(reg_req.valid), 32'd1);
      chk("write", 32'(reg_req.write), 32'(v.we));
      chk("addr", reg_req.addr, v.addr);
      chk("wdata", reg_req.wdata, v.wdata);
      chk("wstrb", 32'(reg_req.wstrb), v.we ? 32'(v.be) : 32'd0);
      chk("rvalid_acc", 32'(obi_rsp.rvalid), 32'd0);
      chk("timeout", 32'(timeout), (v.exp_to && k == TO - 1) ? 32'd1 : 32'd0);
      if (k == v.delay || k == TO - 1) done = 1'b1;
      k++;
      @(negedge clk);
    end
    reg_rsp.ready = 1'b0;
    reg_rsp.rdata = 32'h1111_2222;
    reg_rsp.error = 1'b0;
    #1;
    chk("rvalid", 32'(obi_rsp.rvalid), 32'd1);
    chk("valid_resp", 32'(reg_req.valid), 32'd0);
    chk("rdata", obi_rsp.r.rdata, v.exp_rdata);
    chk("rid", 32'(obi_rsp.r.rid), 32'(v.aid));
    chk("err", 32'(obi_rsp.r.err), 32'(v.exp_err));
    chk("timeout_resp", 32'(timeout), 32'd0);
    // A late ready after a timeout must not produce anything.
    reg_rsp.ready = 1'b1;
    @(negedge clk);
    #1;
    chk("rvalid_once", 32'(obi_rsp.rvalid), 32'd0);
    chk("valid_idle", 32'(reg_req.valid), 32'd0);
    reg_rsp.ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    obi_req = '0;
    reg_rsp = '0;

    //            addr          we  be       wdata         aid  dly rsp_rdata     err   exp_rdata     exp_err to
    vecs[0] = '{32'h0300_2004, 0, 4'b0000, 32'h0,        3'd5, 0,  32'h0000_00A5, 1'b0, 32'h0000_00A5, 1'b0, 1'b0};
    vecs[1] = '{32'h0300_1008, 1, 4'b0011, 32'hDEAD_BEEF, 3'd1, 4,  32'h0000_1234, 1'b0, 32'h0,        1'b0, 1'b0};
    vecs[2] = '{32'h0300_200C, 0, 4'b1111, 32'h0,        3'd2, 1,  32'h0000_0055, 1'b1, 32'h0000_0055, 1'b1, 1'b0};
    vecs[3] = '{32'h0300_2010, 0, 4'b1111, 32'h0,        3'd6, 20, 32'h0000_0099, 1'b0, 32'hBADC_AB1E, 1'b1, 1'b1};
    vecs[4] = '{32'h0300_2014, 0, 4'b1111, 32'h0,        3'd3, 7,  32'h0000_0077, 1'b0, 32'h0000_0077, 1'b0, 1'b0};
    vecs[5] = '{32'h0300_0000, 1, 4'b1111, 32'h1234_5678, 3'd7, 0,  32'hFFFF_FFFF, 1'b1, 32'h0,        1'b1, 1'b0};

    repeat (3) @(negedge clk);
    obi_req.req = 1'b1;
    #1;
    chk("rst_gnt", 32'(obi_rsp.gnt), 32'd0);
    obi_req.req = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_rvalid", 32'(obi_rsp.rvalid), 32'd0);
    chk("rst_valid", 32'(reg_req.valid), 32'd0);
    chk("rst_rdata", obi_rsp.r.rdata, 32'd0);
    chk("rst_rid", 32'(obi_rsp.r.rid), 32'd0);
    chk("rst_wstrb", 32'(reg_req.wstrb), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    for (int i = 0; i < 6; i++) run_txn(vecs[i]);

    // Back-to-back: three reads, ready held high.
    @(negedge clk);
    reg_rsp.ready   = 1'b1;
    reg_rsp.rdata   = 32'h0000_0042;
    reg_rsp.error   = 1'b0;
    obi_req.req     = 1'b1;
    obi_req.a.we    = 1'b0;
    obi_req.a.addr  = 32'h0300_2000;
    obi_req.a.aid   = 3'd1;
    #1 chk("b2b_gnt1", 32'(obi_rsp.gnt), 32'd1);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clk);
      obi_req.a.aid = 3'(t + 1);
      if (t == 3) obi_req.req = 1'b0;
      #1;
      chk("b2b_acc_valid", 32'(reg_req.valid), 32'd1);
      chk("b2b_acc_gnt", 32'(obi_rsp.gnt), 32'd0);
      chk("b2b_acc_rvalid", 32'(obi_rsp.rvalid), 32'd0);
      @(negedge clk);
      #1;
      chk("b2b_rvalid", 32'(obi_rsp.rvalid), 32'd1);
      chk("b2b_rid", 32'(obi_rsp.r.rid), 32'(t));
      chk("b2b_rdata", obi_rsp.r.rdata, 32'h0000_0042);
      chk("b2b_resp_valid", 32'(reg_req.valid), 32'd0);
      chk("b2b_resp_gnt", 32'(obi_rsp.gnt), (t < 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    #1 chk("b2b_idle_rvalid", 32'(obi_rsp.rvalid), 32'd0);
    reg_rsp.ready = 1'b0;

    // Reset while in ACCESS: no response ever.
    @(negedge clk);
    obi_req.req   = 1'b1;
    obi_req.a.aid = 3'd4;
    #1 chk("rstm_gnt", 32'(obi_rsp.gnt), 32'd1);
    @(negedge clk);
    obi_req.req = 1'b0;
    #1 chk("rstm_valid_pre", 32'(reg_req.valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstm_valid", 32'(reg_req.valid), 32'd0);
    chk("rstm_rvalid", 32'(obi_rsp.rvalid), 32'd0);
    chk("rstm_gnt0", 32'(obi_rsp.gnt), 32'd0);
    reg_rsp.ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("rstm_no_rvalid", 32'(obi_rsp.rvalid), 32'd0);
      chk("rstm_no_valid", 32'(reg_req.valid), 32'd0);
    end
    reg_rsp.ready = 1'b0;
    run_txn(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
